// File: rtl/fpu_pkg.sv
// Shared FPU definitions: divider write-back entry layout, special-value
// constants used by both the divider and its write-back stage, and the
// saturating counter helper.
package fpu_pkg;

   localparam int unsigned COUNT_W      = 16;
   localparam int unsigned WB_TAG_MAX_W = 8;

   localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;
   localparam logic [31:0] FP_INF_MASK = 32'h7F80_0000;

   // Tag field is sized for the widest issue tag in use; narrower tags are
   // zero-extended into it.
   typedef struct packed {
      logic [31:0]             result;
      logic                    error;
      logic                    overflow;
      logic [WB_TAG_MAX_W-1:0] tag;
   } wb_entry_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
      return (v == '1) ? v : v + COUNT_W'(1);
   endfunction

endpackage

// File: rtl/fpu_wb_fifo.sv
// Generic register-array FIFO. Pointers carry one extra wrap bit so that
// full and empty are distinguished without a separate count register.
// No fall-through: a written entry becomes visible on the next cycle.
module fpu_wb_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wptr;
   logic [PW-1:0]    rptr;
   logic             push;
   logic             pop;

   assign full    = (wptr[PW-1] != rptr[PW-1]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign empty   = (wptr == rptr);
   assign push    = wr_en && !full && !reset;
   assign pop     = rd_en && !empty;
   assign level   = wptr - rptr;
   assign rd_data = mem[rptr[AW-1:0]];

   // Pointer advance; reset discards every stored entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + PW'(1);
         if (pop)  rptr <= rptr + PW'(1);
      end
   end

   // Storage write; contents are intentionally left unreset.
   always_ff @(posedge clk) begin
      if (push) mem[wptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/fpu_div_writeback.sv
// Divider result write-back stage: buffers divider results in order and
// keeps sticky exception flags for software status reads.
// Optional feature macro: FPU_WB_COUNTERS_EN adds saturating error/overflow
// event counters (err_count, ovf_count). TAG_W must not exceed WB_TAG_MAX_W.
module fpu_div_writeback
   import fpu_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned TAG_W = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            in_result,
   input  logic                   in_error,
   input  logic                   in_overflow,
   input  logic [TAG_W-1:0]       in_tag,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            out_result,
   output logic                   out_error,
   output logic                   out_overflow,
   output logic [TAG_W-1:0]       out_tag,
   output logic [$clog2(DEPTH):0] level,
   input  logic                   flags_clear,
   output logic                   sticky_error,
   output logic                   sticky_overflow
`ifdef FPU_WB_COUNTERS_EN
   ,
   output logic [COUNT_W-1:0]     err_count,
   output logic [COUNT_W-1:0]     ovf_count
`endif
);

   wb_entry_t wr_entry;
   wb_entry_t head;
   logic      full;
   logic      empty;
   logic      push;
   logic      unused_head_tag;

   assign wr_entry = '{result:   in_result,
                       error:    in_error,
                       overflow: in_overflow,
                       tag:      WB_TAG_MAX_W'(in_tag)};

   fpu_wb_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(wb_entry_t))
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (in_valid),
      .wr_data (wr_entry),
      .rd_en   (out_ready),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .level   (level)
   );

   assign in_ready        = !full;
   assign out_valid       = !empty;
   assign push            = in_valid && in_ready;
   assign out_result      = head.result;
   assign out_error       = head.error;
   assign out_overflow    = head.overflow;
   assign out_tag         = head.tag[TAG_W-1:0];
   assign unused_head_tag = |head.tag;

   // Sticky flags: a setting push in the same cycle as a clear wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         sticky_error    <= 1'b0;
         sticky_overflow <= 1'b0;
      end else begin
         sticky_error    <= (sticky_error    && !flags_clear) || (push && in_error);
         sticky_overflow <= (sticky_overflow && !flags_clear) || (push && in_overflow);
      end
   end

`ifdef FPU_WB_COUNTERS_EN
   // Saturating event counters; clear plus increment restarts at one.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_count <= '0;
         ovf_count <= '0;
      end else begin
         if (push && in_error)
            err_count <= flags_clear ? COUNT_W'(1) : sat_inc(err_count);
         else if (flags_clear)
            err_count <= '0;
         if (push && in_overflow)
            ovf_count <= flags_clear ? COUNT_W'(1) : sat_inc(ovf_count);
         else if (flags_clear)
            ovf_count <= '0;
      end
   end
`endif

endmodule
